// File: rtl/model_pwm_pkg.sv
// Shared definitions for the switching-converter model stimulus blocks:
// default widths, the counter reset value and the duty/period pair that is
// double-buffered by the PWM generator and consumed by the model wrappers.
package model_pwm_pkg;

  localparam int CNT_WIDTH_DEF = 16;
  localparam int PRE_WIDTH_DEF = 16;

  // Value every counter returns to on reset, disable or wrap.
  localparam int CNT_RST = 0;

  // One duty/period set. The shadow copy is written by cfg_load and the
  // active copy is refreshed from it only at a carrier wrap.
  typedef struct packed {
    logic [CNT_WIDTH_DEF-1:0] duty;
    logic [CNT_WIDTH_DEF-1:0] period;
  } pwm_cfg_t;

  localparam pwm_cfg_t PWM_CFG_RST = '0;

endpackage

// File: rtl/model_ce_prescaler.sv
// Model step-enable prescaler: divides aclk by prescaler_div+1 and emits a
// registered one-cycle ce. tick is the combinational "ce next cycle" flag
// so a consumer can precompute registered outputs aligned with ce.
module model_ce_prescaler
  import model_pwm_pkg::*;
#(
  parameter int PRE_WIDTH = PRE_WIDTH_DEF
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [PRE_WIDTH-1:0] prescaler_div,
  output logic                 ce,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] pre_cnt;

  // The divider is compared live; lowering it below pre_cnt lets the counter
  // run on to its natural roll-over instead of clamping.
  assign tick = enable && (pre_cnt == prescaler_div);

  // Prescaler counter and registered ce; disable parks the counter at zero.
  always_ff @(posedge aclk) begin
    // NOTE: non-blocking (<=) for every flop so all registers sample the
    // pre-edge values; blocking here would create order-dependent races.
    if (reset || !enable) begin
      pre_cnt <= PRE_WIDTH'(CNT_RST);
      ce      <= 1'b0;
    end else begin
      pre_cnt <= tick ? PRE_WIDTH'(CNT_RST) : pre_cnt + PRE_WIDTH'(1);
      ce      <= tick;
    end
  end

endmodule

// File: rtl/model_pwm_step_gen.sv
// PWM stimulus for the switching-converter models: a prescaled step enable
// ce, a sawtooth carrier advanced on each ce, and a registered switch
// command s1 compared against a double-buffered duty. The model captures
// s1 on the same ce, so s1 only ever changes on the closing edge of a ce
// cycle. The shared struct fixes the stored width, so keep CNT_WIDTH at
// the package default.
module model_pwm_step_gen
  import model_pwm_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int PRE_WIDTH = PRE_WIDTH_DEF
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [PRE_WIDTH-1:0] prescaler_div,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] duty,
  input  logic                 cfg_load,
  output logic                 ce,
  output logic                 s1,
  output logic [CNT_WIDTH-1:0] carrier,
  output logic                 period_start
);

  logic                 tick;
  pwm_cfg_t             cfg_sh;
  pwm_cfg_t             cfg_act;
  pwm_cfg_t             cfg_act_nxt;
  logic [CNT_WIDTH-1:0] carrier_nxt;
  logic                 wrap;
  logic                 s1_nxt;
  logic                 period_start_nxt;

  model_ce_prescaler #(
    .PRE_WIDTH(PRE_WIDTH)
  ) u_prescaler (
    .aclk         (aclk),
    .reset        (reset),
    .enable       (enable),
    .prescaler_div(prescaler_div),
    .ce           (ce),
    .tick         (tick)
  );

  // Next carrier, active set and comparator result for the closing edge of
  // this cycle; period_start is precomputed so it lines up with the next ce.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // a value unassigned; a missing default here would infer a latch.
    cfg_act_nxt      = cfg_act;
    carrier_nxt      = carrier;
    wrap             = (carrier == CNT_WIDTH'(cfg_act.period));
    if (ce) begin
      if (wrap) begin
        carrier_nxt = CNT_WIDTH'(CNT_RST);
        cfg_act_nxt = cfg_sh;
      end else begin
        carrier_nxt = carrier + CNT_WIDTH'(1);
      end
    end
    // Compare against the values being written so a new duty shows on the
    // very first step of the new period.
    s1_nxt           = (carrier_nxt < CNT_WIDTH'(cfg_act_nxt.duty));
    // Next cycle is a ce cycle that will wrap when its carrier hits the top.
    period_start_nxt = tick && (carrier_nxt == CNT_WIDTH'(cfg_act_nxt.period));
  end

  // Shadow capture, active refresh on wrap, carrier and registered outputs.
  always_ff @(posedge aclk) begin
    if (reset) begin
      cfg_sh       <= PWM_CFG_RST;
      cfg_act      <= PWM_CFG_RST;
      carrier      <= CNT_WIDTH'(CNT_RST);
      s1           <= 1'b0;
      period_start <= 1'b0;
    end else begin
      // A load coinciding with a wrap lands after the wrap has already
      // transferred the previous shadow contents.
      if (cfg_load) begin
        cfg_sh <= '{duty:   CNT_WIDTH_DEF'(duty),
                    period: CNT_WIDTH_DEF'(period)};
      end
      if (!enable) begin
        carrier      <= CNT_WIDTH'(CNT_RST);
        s1           <= 1'b0;
        period_start <= 1'b0;
      end else begin
        carrier      <= carrier_nxt;
        cfg_act      <= cfg_act_nxt;
        period_start <= period_start_nxt;
        if (ce) begin
          s1 <= s1_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_model_pwm_step_gen.sv
// Directed bench for model_pwm_step_gen: inputs change just after the falling
// edge and outputs are sampled on the falling edge, so every sample shows the
// state left by the preceding rising edge.
module tb_model_pwm_step_gen;

  logic        aclk;
  logic        reset;
  logic        enable;
  logic [15:0] prescaler_div;
  logic [15:0] period;
  logic [15:0] duty;
  logic        cfg_load;
  logic        ce;
  logic        s1;
  logic [15:0] carrier;
  logic        period_start;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic        ld;
    logic [15:0] per;
    logic [15:0] dut;
    logic        e_ce;
    logic        e_s1;
    logic [15:0] e_car;
    logic        e_ps;
  } vec_t;

  vec_t vecs [14];

  model_pwm_step_gen dut (
    .aclk         (aclk),
    .reset        (reset),
    .enable       (enable),
    .prescaler_div(prescaler_div),
    .period       (period),
    .duty         (duty),
    .cfg_load     (cfg_load),
    .ce           (ce),
    .s1           (s1),
    .carrier      (carrier),
    .period_start (period_start)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_ce, input logic e_s1,
                            input logic [15:0] e_car, input logic e_ps);
    check({tag, " ce"},           32'(ce),           32'(e_ce));
    check({tag, " s1"},           32'(s1),           32'(e_s1));
    check({tag, " carrier"},      32'(carrier),      32'(e_car));
    check({tag, " period_start"}, 32'(period_start), 32'(e_ps));
  endtask

  // Advance at least one cycle and stop on the first period_start (bounded).
  task automatic wait_ps(input string tag, output int n);
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (period_start !== 1'b1 && n < 200);
    check({tag, " period_start reached"}, 32'(period_start), 32'd1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    cfg_load = 1'b0;
    @(negedge aclk);
    reset    = 1'b0;
  endtask

  task automatic load_cfg(input logic [15:0] p, input logic [15:0] d);
    period   = p;
    duty     = d;
    cfg_load = 1'b1;
    @(negedge aclk);
    cfg_load = 1'b0;
  endtask

  initial begin
    int n;
    int s1_hi;
    int ps_cnt;
    logic [15:0] car;
    logic        exp_ce;
    logic [15:0] dis_car [5];
    logic        dis_ce  [5];
    logic        dis_s1  [5];

    // ---------------- reset state ----------------
    reset         = 1'b1;
    enable        = 1'b1;
    cfg_load      = 1'b0;
    prescaler_div = 16'd0;
    period        = 16'd5;
    duty          = 16'd2;
    @(negedge aclk);
    @(negedge aclk);
    check_outs("reset", 1'b0, 1'b0, 16'd0, 1'b0);

    // ---------------- div=1, period 9, duty 3 ----------------
    reset         = 1'b0;
    enable        = 1'b0;
    prescaler_div = 16'd1;
    load_cfg(16'd9, 16'd3);
    enable = 1'b1;
    wait_ps("t1 first", n);
    check("t1 first ce latency", 32'(n), 32'd2);
    check_outs("t1 first", 1'b1, 1'b0, 16'd0, 1'b1);
    s1_hi  = 0;
    ps_cnt = 0;
    for (int i = 1; i <= 44; i++) begin
      @(negedge aclk);
      exp_ce = (i % 2 == 0);
      car    = 16'(((i - 1) / 2) % 10);
      check_outs($sformatf("t1 i=%0d", i), exp_ce, (car < 16'd3), car,
                 exp_ce && (car == 16'd9));
      if (i <= 40) begin
        if (ce && s1) s1_hi++;
        if (period_start) ps_cnt++;
      end
    end
    check("t1 s1 high ce count over 20 ce", 32'(s1_hi), 32'd6);
    check("t1 period_start count over 20 ce", 32'(ps_cnt), 32'd2);

    // ---------------- disable for 5 cycles mid-period ----------------
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      check_outs($sformatf("dis k=%0d", k), 1'b0, 1'b0, 16'd0, 1'b0);
    end
    enable  = 1'b1;
    dis_ce  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    dis_car = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2};
    dis_s1  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int j = 0; j < 5; j++) begin
      @(negedge aclk);
      check_outs($sformatf("reen j=%0d", j), dis_ce[j], dis_s1[j], dis_car[j], 1'b0);
    end

    // ---------------- reset mid-period, shadows cleared ----------------
    reset = 1'b1;
    @(negedge aclk);
    check_outs("midrst", 1'b0, 1'b0, 16'd0, 1'b0);
    reset = 1'b0;
    @(negedge aclk);
    check_outs("postrst r1", 1'b0, 1'b0, 16'd0, 1'b0);
    @(negedge aclk);
    check_outs("postrst r2", 1'b1, 1'b0, 16'd0, 1'b1);
    @(negedge aclk);
    check_outs("postrst r3", 1'b0, 1'b0, 16'd0, 1'b0);
    @(negedge aclk);
    check_outs("postrst r4", 1'b1, 1'b0, 16'd0, 1'b1);

    // ---------------- table: div=0, period 4, duty 2 then 4 ----------------
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'd4, 16'd2, 1'b0, 1'b0, 16'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'd4, 16'd2, 1'b1, 1'b0, 16'd0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'd4, 16'd2, 1'b1, 1'b1, 16'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'd4, 16'd2, 1'b1, 1'b1, 16'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'd4, 16'd2, 1'b1, 1'b0, 16'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'd4, 16'd4, 1'b1, 1'b0, 16'd3, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'd4, 16'd4, 1'b1, 1'b0, 16'd4, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'd4, 16'd4, 1'b1, 1'b1, 16'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'd4, 16'd4, 1'b1, 1'b1, 16'd1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'd4, 16'd4, 1'b1, 1'b1, 16'd2, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'd4, 16'd4, 1'b1, 1'b1, 16'd3, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 16'd4, 16'd4, 1'b1, 1'b0, 16'd4, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 16'd4, 16'd4, 1'b1, 1'b1, 16'd0, 1'b0};
    prescaler_div = 16'd0;
    for (int v = 0; v < 14; v++) begin
      reset    = vecs[v].rst;
      enable   = vecs[v].en;
      cfg_load = vecs[v].ld;
      period   = vecs[v].per;
      duty     = vecs[v].dut;
      @(negedge aclk);
      check_outs($sformatf("tbl v=%0d", v), vecs[v].e_ce, vecs[v].e_s1,
                 vecs[v].e_car, vecs[v].e_ps);
    end
    cfg_load = 1'b0;

    // ---------------- duty 0, then duty = period+1 ----------------
    do_reset();
    prescaler_div = 16'd0;
    load_cfg(16'd5, 16'd0);
    enable = 1'b1;
    wait_ps("t3", n);
    check("t3 first ce latency", 32'(n), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      check($sformatf("t3 duty0 s1 i=%0d", i), 32'(s1), 32'd0);
      check($sformatf("t3 duty0 carrier i=%0d", i), 32'(carrier), 32'(i));
      check($sformatf("t3 duty0 ps i=%0d", i), 32'(period_start), 32'(i == 5));
      if (i == 0) begin
        period   = 16'd5;
        duty     = 16'd6;
        cfg_load = 1'b1;
      end else begin
        cfg_load = 1'b0;
      end
    end
    for (int j = 0; j < 12; j++) begin
      @(negedge aclk);
      check($sformatf("t3 full s1 j=%0d", j), 32'(s1), 32'd1);
      check($sformatf("t3 full carrier j=%0d", j), 32'(carrier), 32'(j % 6));
    end

    // ---------------- period 0, duty 1, div 2 ----------------
    do_reset();
    prescaler_div = 16'd2;
    load_cfg(16'd0, 16'd1);
    enable = 1'b1;
    wait_ps("t4", n);
    check("t4 first ce latency", 32'(n), 32'd3);
    check_outs("t4 first", 1'b1, 1'b0, 16'd0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge aclk);
      check_outs($sformatf("t4 i=%0d", i), (i % 3 == 0), 1'b1, 16'd0, (i % 3 == 0));
    end

    // ---------------- cfg_load in the wrap cycle, period 7 -> 3 ----------------
    do_reset();
    prescaler_div = 16'd0;
    load_cfg(16'd7, 16'd2);
    enable = 1'b1;
    wait_ps("t5 first", n);
    wait_ps("t5 wrap", n);
    check("t5 wrap distance", 32'(n), 32'd8);
    check("t5 wrap carrier", 32'(carrier), 32'd7);
    load_cfg(16'd3, 16'd2);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5 old carrier i=%0d", i), 32'(carrier), 32'(i));
      check($sformatf("t5 old ps i=%0d", i), 32'(period_start), 32'(i == 7));
      check($sformatf("t5 old s1 i=%0d", i), 32'(s1), 32'(i < 2));
      @(negedge aclk);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5 new carrier i=%0d", i), 32'(carrier), 32'(i % 4));
      check($sformatf("t5 new ps i=%0d", i), 32'(period_start), 32'(i % 4 == 3));
      @(negedge aclk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
